// File: rtl/id_stream_encoder.sv
// Instruction Id stream encoder: validates field-level requests, encodes them to 7-bit Ids,
// buffers them in a small FIFO and writes them to consecutive instruction-memory addresses.
module id_stream_encoder #(
    parameter int unsigned ADDR_W = 8,
    parameter int unsigned DEPTH  = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start_i,
    input  logic [ADDR_W-1:0] base_addr_i,
    input  logic [ADDR_W-1:0] length_i,
    input  logic              req_valid_i,
    output logic              req_ready_o,
    input  logic [1:0]        req_type_i,
    input  logic [2:0]        req_op_i,
    input  logic [1:0]        req_is_i,
    output logic              wr_valid_o,
    input  logic              wr_ready_i,
    output logic [ADDR_W-1:0] wr_addr_o,
    output logic [6:0]        wr_id_o,
    output logic              busy_o,
    output logic              done_o,
    output logic [7:0]        err_cnt_o
);

    localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef enum logic [1:0] {StIdle, StLoad, StDone} state_e;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] base_q, base_d;
    logic [ADDR_W-1:0] len_q, len_d;
    logic [ADDR_W-1:0] acc_cnt_q, acc_cnt_d;
    logic [ADDR_W-1:0] wr_cnt_q, wr_cnt_d;
    logic [7:0]        err_cnt_q, err_cnt_d;
    logic [PtrW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [PtrW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PtrW:0]     fill_q, fill_d;
    logic [6:0]        mem_q [DEPTH];

    logic       fifo_full, fifo_empty;
    logic       start_ok, push, pop;
    logic [6:0] enc_id, push_id;
    logic       enc_legal;

    always_comb begin
        enc_id    = '0;
        enc_legal = 1'b0;
        case (req_type_i)
            2'b01: begin
                enc_id    = {2'b01, req_op_i, req_is_i};
                enc_legal = 1'b1;
            end
            2'b10: begin
                enc_id    = {2'b10, req_op_i[0], 4'b0000};
                enc_legal = (req_op_i[2:1] == 2'b00) && (req_is_i == 2'b00);
            end
            2'b11: begin
                enc_id    = {2'b11, req_op_i[1:0], 3'b000};
                enc_legal = !req_op_i[2] && (req_is_i == 2'b00);
            end
            default: begin
                enc_id    = '0;
                enc_legal = (req_op_i == 3'b000) && (req_is_i == 2'b00);
            end
        endcase
        // Illegal requests become a system NOP but still occupy a slot in the session.
        push_id = enc_legal ? enc_id : 7'b0000000;
    end

    assign fifo_full   = (fill_q == (PtrW+1)'(DEPTH));
    assign fifo_empty  = (fill_q == '0);
    assign req_ready_o = (state_q == StLoad) && !fifo_full && (acc_cnt_q < len_q);
    assign wr_valid_o  = !fifo_empty;
    assign wr_id_o     = mem_q[rd_ptr_q];
    assign wr_addr_o   = base_q + wr_cnt_q;
    assign busy_o      = (state_q == StLoad);
    assign done_o      = (state_q == StDone);
    assign err_cnt_o   = err_cnt_q;

    assign start_ok = start_i && (state_q != StLoad);
    assign push     = req_valid_i && req_ready_o;
    assign pop      = wr_valid_o && wr_ready_i;

    always_comb begin
        state_d   = state_q;
        base_d    = base_q;
        len_d     = len_q;
        acc_cnt_d = acc_cnt_q;
        wr_cnt_d  = wr_cnt_q;
        err_cnt_d = err_cnt_q;
        rd_ptr_d  = rd_ptr_q;
        wr_ptr_d  = wr_ptr_q;
        fill_d    = fill_q;
        if (start_ok) begin
            base_d    = base_addr_i;
            len_d     = length_i;
            acc_cnt_d = '0;
            wr_cnt_d  = '0;
            err_cnt_d = '0;
            rd_ptr_d  = '0;
            wr_ptr_d  = '0;
            fill_d    = '0;
            state_d   = (length_i == '0) ? StDone : StLoad;
        end else begin
            if (push) begin
                acc_cnt_d = acc_cnt_q + ADDR_W'(1);
                wr_ptr_d  = wr_ptr_q + PtrW'(1);
                if (!enc_legal && (err_cnt_q != 8'hff)) begin
                    err_cnt_d = err_cnt_q + 8'd1;
                end
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PtrW'(1);
                wr_cnt_d = wr_cnt_q + ADDR_W'(1);
                if ((state_q == StLoad) && (wr_cnt_q + ADDR_W'(1) == len_q)) begin
                    state_d = StDone;
                end
            end
            case ({push, pop})
                2'b10:   fill_d = fill_q + (PtrW+1)'(1);
                2'b01:   fill_d = fill_q - (PtrW+1)'(1);
                default: fill_d = fill_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            base_q    <= '0;
            len_q     <= '0;
            acc_cnt_q <= '0;
            wr_cnt_q  <= '0;
            err_cnt_q <= '0;
            rd_ptr_q  <= '0;
            wr_ptr_q  <= '0;
            fill_q    <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            state_q   <= state_d;
            base_q    <= base_d;
            len_q     <= len_d;
            acc_cnt_q <= acc_cnt_d;
            wr_cnt_q  <= wr_cnt_d;
            err_cnt_q <= err_cnt_d;
            rd_ptr_q  <= rd_ptr_d;
            wr_ptr_q  <= wr_ptr_d;
            fill_q    <= fill_d;
            if (push) begin
                mem_q[wr_ptr_q] <= push_id;
            end
        end
    end

endmodule

// File: doc/id_stream_encoder.md
# id_stream_encoder

Producer side of the 7-bit instruction Id interface consumed by the control unit. It accepts field-level instruction requests (type, op, IS) from the host loader over a valid/ready handshake, validates and canonically encodes each into a 7-bit Id, buffers the results in a small FIFO, and writes them to consecutive instruction-memory addresses. A session starts on `start` and finishes after `length` words have been written. Illegal requests are replaced with a system NOP and counted.

## Interface
- `ADDR_W`, 8: instruction-memory address width.
- `DEPTH`, 4: FIFO depth in entries, power of two, ≥2.
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `start` in 1: one-cycle pulse that begins a session. Honoured only in IDLE or DONE.
- `base_addr` in ADDR_W: first write address, sampled on an honoured `start`.
- `length` in ADDR_W: number of words in the session, sampled on an honoured `start`.
- `req_valid` in 1: request valid.
- `req_ready` out 1: request accepted this cycle when `req_valid` is also high.
- `req_type` in 2: 00 system, 01 data-processing, 10 memory, 11 control.
- `req_op` in 3: operation field.
- `req_is` in 2: IS flags. IS[1]=1 selects the immediate operand.
- `wr_valid` out 1: memory write pending.
- `wr_ready` in 1: memory accepts the write.
- `wr_addr` out ADDR_W: write address.
- `wr_id` out 7: encoded Id.
- `busy` out 1: high in LOAD.
- `done` out 1: high in DONE.
- `err_cnt` out 8: count of illegal requests; saturates at 255.

## Operation
- FSM states: IDLE, LOAD, DONE.
  - IDLE→LOAD on `start` when `length`≠0.
  - IDLE→DONE on `start` when `length`=0.
  - LOAD→DONE when written count reaches `length`.
  - DONE→LOAD (or DONE→DONE if `length`=0) on `start`.
  - `start` during LOAD is ignored.
- On an honoured `start`: accepted count, written count and `err_cnt` clear to 0, and the FIFO is emptied.
- `req_ready` = LOAD && FIFO not full (registered state) && accepted count < `length`. A pop in the same cycle does not free space for a same-cycle push.
- Encoding, applied to each accepted request:
  - Data-processing: Id = {01, op[2:0], is[1:0]}. Always legal.
  - Memory: Id = {10, op[0], 00, 00}. Legal only if op[2:1]=00 and is=00. op[0]=1 is STR, 0 is LDR.
  - Control: Id = {11, op[1:0], 000}. Legal only if op[2]=0 and is=00.
  - System: Id = 0000000. Legal only if op=000 and is=00.
  - Illegal request: a 0000000 (system NOP) is pushed instead and `err_cnt` increments by 1 (saturating). The request still counts toward `length`.
- Write side:
  - `wr_valid` = FIFO not empty; `wr_id` = FIFO head.
  - `wr_addr` = base + written count, modulo 2^ADDR_W (wraps silently).
  - A pop happens when `wr_valid` && `wr_ready`. Written count increments on each pop.
  - `wr_valid`, `wr_addr` and `wr_id` hold stable while `wr_valid` && !`wr_ready`.
- Requests arriving in IDLE or DONE are not accepted (`req_ready`=0).

## Timing
- Reset values: FSM=IDLE, FIFO empty, all counters 0, `req_ready`=0, `wr_valid`=0, `wr_addr`=0, `wr_id`=0, `busy`=0, `done`=0, `err_cnt`=0.
- Reset asserted mid-session aborts immediately: FIFO contents are discarded and no further writes occur.
- Latency: a request accepted at edge N makes `wr_valid` high after edge N (visible in cycle N+1). There is no combinational req→wr path.
- Throughput: 1 word/cycle sustained when `wr_ready` is held high.
- `busy` rises in the cycle after the `start` edge.
- `done` rises in the cycle after the edge on which the final pop occurs; `busy` falls in that same cycle.
- `err_cnt` updates on the accept edge of the illegal request.

## Test plan
- Session with base=0x10, length=4. Send DP {01,000,11}, STR {10,001,00}, LDR {10,000,00}, control {11,010,00} with `wr_ready`=1. Expect writes of 0x23@0x10, 0x50@0x11, 0x40@0x12, 0x70@0x13. `done` rises 1 cycle after the last write; `err_cnt`=0.
- Illegal requests, length=2: memory {10,001,01} and system {00,100,00}. Expect 0x00@base and 0x00@base+1, `err_cnt`=2.
- Backpressure, DEPTH=4: hold `wr_ready`=0 and stream 6 DP requests. `req_ready` drops after 4 accepts and `wr_valid`/`wr_id` stay stable. Release `wr_ready`: all 6 written in order with no loss or duplication.
- Address wrap: ADDR_W=8, base=0xFE, length=3. Expect addresses 0xFE, 0xFF, 0x00.
- Edge cases:
  - `start` with length=0 → DONE next cycle with no writes.
  - `start` pulsed during LOAD → ignored; the session completes unchanged.
  - Requests offered in IDLE → `req_ready`=0.
- Reset with 2 words queued mid-session: after `rst_n` low, all outputs return to reset values asynchronously. After release, `wr_valid` stays 0 until a new `start`.
